// File: rtl/mips_mmio_pkg.sv
// rtl/mips_mmio_pkg.sv - shared constants for the data-memory / MMIO responder
package mips_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [5:0] OFF_CYCLE   = 6'd0;
    localparam logic [5:0] OFF_TXDATA  = 6'd1;
    localparam logic [5:0] OFF_STATUS  = 6'd2;
    localparam logic [5:0] OFF_SCRATCH = 6'd3;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;

    function automatic logic [31:0] status_word(input logic [15:0] cnt, input logic empty,
                                                input logic full, input logic ovf);
        logic [31:0] w;
        w           = '0;
        w[15:0]     = cnt;
        w[ST_EMPTY] = empty;
        w[ST_FULL]  = full;
        w[ST_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// rtl/dmem_mmio_responder_if.sv - core load/store port plus TX byte stream
interface dmem_mmio_responder_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    modport master (
        output memwrite, addr, writedata, out_ready,
        input  readdata, out_valid, out_data
    );

    modport slave (
        input  memwrite, addr, writedata, out_ready,
        output readdata, out_valid, out_data
    );
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// rtl/dmem_mmio_responder_tx_fifo.sv - circular TX byte FIFO, registered head, no fall-through
module tx_fifo #(
    parameter  int FIFO_DEPTH = 8,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    output logic          push_accepted,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push at full still lands.
    always_comb begin
        do_pop        = pop && !empty;
        push_accepted = push && (!full || do_pop);
        wr_ptr_d      = push_accepted ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q;
        case ({push_accepted, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_accepted) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - word RAM plus CYCLE/TXDATA/STATUS/SCRATCH MMIO window
module dmem_mmio_responder
    import mips_mmio_pkg::*;
#(
    parameter int          DEPTH      = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    dmem_mmio_responder_if.slave bus
);

    localparam int RAW = $clog2(DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    ram_q [DEPTH];
    logic [31:0]    cycle_q, cycle_d;
    logic [31:0]    scratch_q, scratch_d;
    logic           ovf_q, ovf_d;

    logic           mmio;
    logic [5:0]     off;
    logic [RAW-1:0] ram_idx;
    logic           ram_we;
    logic           tx_push, tx_push_accepted, tx_pop;
    logic           tx_full, tx_empty;
    logic [7:0]     tx_head;
    logic [CW-1:0]  tx_count;
    logic           unused_addr_bits;

    assign mmio             = (bus.addr[31:8] == MMIO_BASE[31:8]);
    assign off              = bus.addr[7:2];
    assign ram_idx          = bus.addr[RAW+1:2];
    assign unused_addr_bits = ^bus.addr[1:0];

    assign ram_we  = bus.memwrite && !mmio;
    assign tx_push = bus.memwrite && mmio && (off == OFF_TXDATA);
    assign tx_pop  = !tx_empty && bus.out_ready;

    assign bus.out_valid = !tx_empty;
    assign bus.out_data  = tx_head;

    tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (tx_push),
        .push_data     (bus.writedata[7:0]),
        .push_accepted (tx_push_accepted),
        .pop           (tx_pop),
        .pop_data      (tx_head),
        .full          (tx_full),
        .empty         (tx_empty),
        .count         (tx_count)
    );

    // A CYCLE store replaces the increment for that cycle; ovf set beats clear.
    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        scratch_d = scratch_q;
        ovf_d     = ovf_q;
        if (bus.memwrite && mmio) begin
            case (off)
                OFF_CYCLE:   cycle_d   = bus.writedata;
                OFF_SCRATCH: scratch_d = bus.writedata;
                OFF_STATUS:  if (bus.writedata[ST_OVF]) ovf_d = 1'b0;
                default:     ;
            endcase
        end
        if (tx_push && !tx_push_accepted) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= bus.writedata;
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (!mmio) begin
            bus.readdata = ram_q[ram_idx];
        end else begin
            case (off)
                OFF_CYCLE:   bus.readdata = cycle_q;
                OFF_STATUS:  bus.readdata = status_word(16'(tx_count), tx_empty, tx_full, ovf_q);
                OFF_SCRATCH: bus.readdata = scratch_q;
                default:     bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb/tb_dmem_mmio_responder.sv - scoreboard bench for dmem_mmio_responder
module tb_dmem_mmio_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] MB    = 32'hFFFF_FF00;
    localparam logic [31:0] A_CYC = MB;
    localparam logic [31:0] A_TX  = MB + 32'd4;
    localparam logic [31:0] A_ST  = MB + 32'd8;
    localparam logic [31:0] A_SCR = MB + 32'd12;
    localparam logic [31:0] A_UNM = MB + 32'h20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q  [$];
    int          kind_q [$];
    string       name_q [$];
    logic [7:0]  byte_q [$];
    logic        chk_strobe = 1'b0;

    logic [31:0] mon_exp, mon_act;
    int          mon_kind;
    string       mon_name;
    logic [7:0]  mon_byte;

    always @(negedge clk) begin
        if (chk_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: check strobe with no expected entry");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_kind = kind_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = (mon_kind == 0) ? bus.readdata : {31'd0, bus.out_valid};
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", mon_name, mon_act, mon_exp);
                end
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (byte_q.size() == 0) begin
                errors++;
                $display("FAIL stream_byte: unexpected byte %h", bus.out_data);
            end else begin
                mon_byte = byte_q.pop_front();
                if (bus.out_data !== mon_byte) begin
                    errors++;
                    $display("FAIL stream_byte: got %h expected %h", bus.out_data, mon_byte);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input logic [31:0] a, input logic [31:0] e, input string n);
        bus.memwrite = 1'b0;
        bus.addr     = a;
        exp_q.push_back(e);
        kind_q.push_back(0);
        name_q.push_back(n);
        chk_strobe = 1'b1;
        cyc();
        chk_strobe = 1'b0;
    endtask

    task automatic expect_valid(input logic e, input string n);
        bus.memwrite = 1'b0;
        exp_q.push_back({31'd0, e});
        kind_q.push_back(1);
        name_q.push_back(n);
        chk_strobe = 1'b1;
        cyc();
        chk_strobe = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
        cyc();
        bus.memwrite  = 1'b0;
    endtask

    task automatic wr_rd(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                         input string n);
        bus.memwrite  = 1'b1;
        bus.addr      = a;
        bus.writedata = d;
        exp_q.push_back(e);
        kind_q.push_back(0);
        name_q.push_back(n);
        chk_strobe = 1'b1;
        cyc();
        chk_strobe    = 1'b0;
        bus.memwrite  = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b, input bit expect_out);
        if (expect_out) byte_q.push_back(b);
        wr(A_TX, {24'd0, b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.memwrite  = 1'b0;
        bus.addr      = '0;
        bus.writedata = '0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // CYCLE counts from 0 right after reset, then reset-state registers
        expect_rd(A_CYC, 32'd0, "cycle_after_reset_0");
        expect_rd(A_CYC, 32'd1, "cycle_after_reset_1");
        expect_rd(A_CYC, 32'd2, "cycle_after_reset_2");
        expect_rd(A_ST,  32'h0001_0000, "status_reset");
        expect_rd(A_SCR, 32'd0, "scratch_reset");
        expect_valid(1'b0, "out_valid_reset");

        wr(A_CYC, 32'hFFFF_FFFE);
        expect_rd(A_CYC, 32'hFFFF_FFFE, "cycle_loaded");
        expect_rd(A_CYC, 32'hFFFF_FFFF, "cycle_max");
        expect_rd(A_CYC, 32'h0000_0000, "cycle_wrap");

        // RAM: read during write returns the old word, then aliasing
        wr(32'h10, 32'h1111_1111);
        wr_rd(32'h10, 32'hDEAD_BEEF, 32'h1111_1111, "ram_read_during_write_old");
        expect_rd(32'h10, 32'hDEAD_BEEF, "ram_read_new");
        expect_rd(32'h10 + 32'(4 * DEPTH), 32'hDEAD_BEEF, "ram_alias");

        // FIFO fill, overflow, drain
        for (int i = 0; i < 8; i++) push_tx(8'h41 + 8'(i), 1'b1);
        expect_rd(A_ST, 32'h0002_0008, "status_full");
        push_tx(8'h49, 1'b0);
        expect_rd(A_ST, 32'h0006_0008, "status_full_ovf");
        expect_rd(A_TX, 32'd0, "txdata_reads_zero");
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        bus.out_ready = 1'b0;
        expect_valid(1'b0, "out_valid_drained");
        expect_rd(A_ST, 32'h0005_0000, "status_empty_ovf");
        wr(A_ST, 32'h0004_0000);
        expect_rd(A_ST, 32'h0001_0000, "status_ovf_cleared");

        // Push at full with a same-cycle pop is accepted
        for (int i = 0; i < 8; i++) push_tx(8'h50 + 8'(i), 1'b1);
        bus.out_ready = 1'b1;
        push_tx(8'h58, 1'b1);
        bus.out_ready = 1'b0;
        expect_rd(A_ST, 32'h0002_0008, "full_push_pop_no_ovf");
        push_tx(8'h59, 1'b0);
        expect_rd(A_ST, 32'h0006_0008, "full_ovf_again");
        wr(A_ST, 32'h0004_0000);
        expect_rd(A_ST, 32'h0002_0008, "ovf_clear_keeps_count");
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        bus.out_ready = 1'b0;
        expect_valid(1'b0, "out_valid_drained_2");

        // Reset with bytes queued discards them; RAM survives
        push_tx(8'h61, 1'b0);
        push_tx(8'h62, 1'b0);
        push_tx(8'h63, 1'b0);
        wr(A_SCR, 32'hCAFE_F00D);
        expect_rd(A_SCR, 32'hCAFE_F00D, "scratch_rw");
        expect_valid(1'b1, "out_valid_before_reset");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_valid(1'b0, "out_valid_after_reset");
        expect_rd(A_ST, 32'h0001_0000, "status_after_reset");
        expect_rd(A_SCR, 32'd0, "scratch_after_reset");
        expect_rd(32'h10, 32'hDEAD_BEEF, "ram_survives_reset");
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        bus.out_ready = 1'b0;

        // Unmapped offset: write ignored, reads zero, nothing else moves
        wr(A_UNM, 32'h0000_1234);
        expect_rd(A_UNM, 32'd0, "unmapped_reads_zero");
        expect_rd(A_SCR, 32'd0, "unmapped_scratch_untouched");
        expect_rd(A_ST, 32'h0001_0000, "unmapped_status_untouched");
        expect_rd(32'h10, 32'hDEAD_BEEF, "unmapped_ram_untouched");

        cyc();
        checks++;
        if (byte_q.size() != 0) begin
            errors++;
            $display("FAIL stream_leftover: got %0d bytes pending expected 0", byte_q.size());
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL check_leftover: got %0d checks pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
